axi_sram_slave: RTL and testbench

AXI-4 slave responder backed by on-chip SRAM; the target end of `axi4_interface` whose master is the L2 cache's system-memory port. Accepts single-beat and incrementing bursts (1–256 beats) on the read and write channels, serialises them onto one single-port memory, and returns read data and write acknowledgements with full backpressure support. Used as boot/scratch memory in FPGA and simulation tops in place of an external DRAM controller.

---
 rtl/axi_sram_slave_pkg.sv | 16 +
 rtl/axi_sram_slave_if.sv | 50 +++++
 rtl/axi_sram_slave_sram_1p.sv | 25 ++
 rtl/axi_sram_slave.sv | 138 +++++++++++++
 tb/tb_axi_sram_slave.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_sram_slave_pkg.sv
// Shared types and widths for the AXI SRAM slave and its bus interface.
package axi_sram_slave_pkg;

  localparam int unsigned AXI_DATA_WIDTH = 32;
  localparam int unsigned AXI_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle,
    StReadData,
    StWriteData,
    StWriteResp
  } axi_slave_state_t;

  typedef logic [7:0] axi_burst_len_t;

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI-4 bus bundle (no strobes, no response codes) between L2 master and SRAM slave.
interface axi4_interface;
  import axi_sram_slave_pkg::*;

  logic                      m_aclk;
  logic                      m_aresetn;

  logic                      m_awvalid;
  logic                      s_awready;
  logic [AXI_ADDR_WIDTH-1:0] m_awaddr;
  axi_burst_len_t            m_awlen;
  logic [2:0]                m_awprot;

  logic                      m_wvalid;
  logic                      s_wready;
  logic [AXI_DATA_WIDTH-1:0] m_wdata;
  logic                      m_wlast;

  logic                      s_bvalid;
  logic                      m_bready;

  logic                      m_arvalid;
  logic                      s_arready;
  logic [AXI_ADDR_WIDTH-1:0] m_araddr;
  axi_burst_len_t            m_arlen;
  logic [2:0]                m_arprot;

  logic                      s_rvalid;
  logic                      m_rready;
  logic [AXI_DATA_WIDTH-1:0] s_rdata;

  modport master (
    output m_aclk, m_aresetn,
    output m_awvalid, m_awaddr, m_awlen, m_awprot, input s_awready,
    output m_wvalid, m_wdata, m_wlast, input s_wready,
    output m_bready, input s_bvalid,
    output m_arvalid, m_araddr, m_arlen, m_arprot, input s_arready,
    output m_rready, input s_rvalid, s_rdata
  );

  modport slave (
    input m_aclk, m_aresetn,
    input m_awvalid, m_awaddr, m_awlen, m_awprot, output s_awready,
    input m_wvalid, m_wdata, m_wlast, output s_wready,
    input m_bready, output s_bvalid,
    input m_arvalid, m_araddr, m_arlen, m_arprot, output s_arready,
    input m_rready, output s_rvalid, s_rdata
  );

endinterface

// File: rtl/axi_sram_slave_sram_1p.sv
// Single-port synchronous SRAM; read data is registered and holds until the next read.
module sram_1p #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SIZE       = 4096
) (
  input  logic                     clk,
  input  logic                     read_en,
  input  logic                     write_en,
  input  logic [$clog2(SIZE)-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]    write_data,
  output logic [DATA_WIDTH-1:0]    read_data
);

  logic [DATA_WIDTH-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[addr] <= write_data;
    end
    if (read_en) begin
      read_data <= mem[addr];
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI-4 burst responder serialising read and write bursts onto one single-port SRAM.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096
) (
  input  logic          clk,
  input  logic          reset_n,
  axi4_interface.slave  axi_bus,
  output logic          wlast_error
);

  localparam int unsigned AddrLsb  = $clog2(AXI_DATA_WIDTH / 8);
  localparam int unsigned WordBits = $clog2(MEM_WORDS);

  typedef logic [WordBits-1:0] word_addr_t;

  axi_slave_state_t          state_q, state_d;
  word_addr_t                addr_q, addr_d;
  axi_burst_len_t            len_q, len_d;   // beats remaining minus one
  logic                      prio_read_q, prio_read_d;

  logic                      mem_re, mem_we;
  word_addr_t                mem_addr;
  logic [AXI_DATA_WIDTH-1:0] mem_rdata;

  logic ar_ready, aw_ready, w_ready, b_valid, r_valid, last_beat;

  assign last_beat = (len_q == '0);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    prio_read_d = prio_read_q;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = addr_q;
    ar_ready    = 1'b0;
    aw_ready    = 1'b0;
    w_ready     = 1'b0;
    b_valid     = 1'b0;
    r_valid     = 1'b0;
    wlast_error = 1'b0;

    unique case (state_q)
      StIdle: begin
        ar_ready = axi_bus.m_arvalid && (!axi_bus.m_awvalid || prio_read_q);
        aw_ready = axi_bus.m_awvalid && (!axi_bus.m_arvalid || !prio_read_q);
        if (ar_ready) begin
          mem_re      = 1'b1;
          mem_addr    = axi_bus.m_araddr[AddrLsb +: WordBits];
          addr_d      = mem_addr;
          len_d       = axi_bus.m_arlen;
          prio_read_d = 1'b0;
          state_d     = StReadData;
        end else if (aw_ready) begin
          addr_d      = axi_bus.m_awaddr[AddrLsb +: WordBits];
          len_d       = axi_bus.m_awlen;
          prio_read_d = 1'b1;
          state_d     = StWriteData;
        end
      end
      StReadData: begin
        r_valid = 1'b1;
        if (axi_bus.m_rready) begin
          if (last_beat) begin
            state_d = StIdle;
          end else begin
            // Prefetch the next word now so rvalid never drops mid-burst.
            mem_re   = 1'b1;
            mem_addr = addr_q + word_addr_t'(1);
            addr_d   = mem_addr;
            len_d    = len_q - axi_burst_len_t'(1);
          end
        end
      end
      StWriteData: begin
        w_ready = 1'b1;
        if (axi_bus.m_wvalid) begin
          mem_we      = 1'b1;
          addr_d      = addr_q + word_addr_t'(1);
          len_d       = len_q - axi_burst_len_t'(1);
          wlast_error = (axi_bus.m_wlast != last_beat);
          if (last_beat) begin
            state_d = StWriteResp;
          end
        end
      end
      StWriteResp: begin
        b_valid = 1'b1;
        if (axi_bus.m_bready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      len_q       <= '0;
      prio_read_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      prio_read_q <= prio_read_d;
    end
  end

  sram_1p #(
    .DATA_WIDTH (AXI_DATA_WIDTH),
    .SIZE       (MEM_WORDS)
  ) u_sram (
    .clk        (clk),
    .read_en    (mem_re),
    .write_en   (mem_we),
    .addr       (mem_addr),
    .write_data (axi_bus.m_wdata),
    .read_data  (mem_rdata)
  );

  // Ready outputs are gated so they stay low while reset is held.
  assign axi_bus.s_arready = ar_ready & reset_n;
  assign axi_bus.s_awready = aw_ready & reset_n;
  assign axi_bus.s_wready  = w_ready;
  assign axi_bus.s_bvalid  = b_valid;
  assign axi_bus.s_rvalid  = r_valid;
  assign axi_bus.s_rdata   = r_valid ? mem_rdata : '0;

  logic unused_ok;
  assign unused_ok = ^{axi_bus.m_awaddr, axi_bus.m_araddr, axi_bus.m_awprot,
                       axi_bus.m_arprot, axi_bus.m_aclk, axi_bus.m_aresetn};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomised bench for axi_sram_slave against an array model of memory contents.
module tb_axi_sram_slave;
  import axi_sram_slave_pkg::*;

  localparam int unsigned MemWords      = 64;
  localparam int unsigned TimeoutCycles = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic wlast_error;

  always #5 clk = ~clk;

  axi4_interface bus ();

  assign bus.m_aclk    = clk;
  assign bus.m_aresetn = reset_n;

  axi_sram_slave #(
    .MEM_WORDS (MemWords)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .axi_bus     (bus),
    .wlast_error (wlast_error)
  );

  logic [AXI_DATA_WIDTH-1:0] ref_mem [MemWords];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int unsigned widx(input logic [31:0] addr);
    return (addr / (AXI_DATA_WIDTH / 8)) % MemWords;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.m_awvalid = 1'b0;
    bus.m_wvalid  = 1'b0;
    bus.m_wlast   = 1'b0;
    bus.m_bready  = 1'b0;
    bus.m_arvalid = 1'b0;
    bus.m_rready  = 1'b0;
  endtask

  task automatic apply_reset();
    idle_bus();
    bus.m_arvalid = 1'b1;
    bus.m_awvalid = 1'b1;
    reset_n = 1'b0;
    #1;
    check_eq("rst_arready", 32'(bus.s_arready), 32'd0);
    check_eq("rst_awready", 32'(bus.s_awready), 32'd0);
    check_eq("rst_wready", 32'(bus.s_wready), 32'd0);
    check_eq("rst_bvalid", 32'(bus.s_bvalid), 32'd0);
    check_eq("rst_rvalid", 32'(bus.s_rvalid), 32'd0);
    check_eq("rst_rdata", bus.s_rdata, 32'd0);
    check_eq("rst_wlast_error", 32'(wlast_error), 32'd0);
    idle_bus();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
  endtask

  task automatic aw_handshake(input logic [31:0] addr, input axi_burst_len_t len);
    int n = 0;
    bus.m_awvalid = 1'b1;
    bus.m_awaddr  = addr;
    bus.m_awlen   = len;
    bus.m_awprot  = 3'($urandom);
    #1;
    while (!bus.s_awready && n < int'(TimeoutCycles)) begin tick(); n++; end
    if (n == int'(TimeoutCycles)) check_eq("aw_timeout", 32'd0, 32'd1);
    tick();
    bus.m_awvalid = 1'b0;
  endtask

  task automatic ar_handshake(input logic [31:0] addr, input axi_burst_len_t len);
    int n = 0;
    bus.m_arvalid = 1'b1;
    bus.m_araddr  = addr;
    bus.m_arlen   = len;
    bus.m_arprot  = 3'($urandom);
    #1;
    while (!bus.s_arready && n < int'(TimeoutCycles)) begin tick(); n++; end
    if (n == int'(TimeoutCycles)) check_eq("ar_timeout", 32'd0, 32'd1);
    tick();
    bus.m_arvalid = 1'b0;
  endtask

  // Drives W beats; early_beat >= 0 raises wlast on that beat as well as the final one.
  task automatic send_w(input int unsigned idx, input axi_burst_len_t len, input int early_beat,
                        input bit gaps, input logic [31:0] data[$]);
    int beat = 0;
    int n = 0;
    bit last_cnt;
    while (beat <= int'(len) && n < int'(TimeoutCycles) * 2) begin
      last_cnt      = (beat == int'(len));
      bus.m_wvalid  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.m_wdata   = data[beat];
      bus.m_wlast   = last_cnt || (beat == early_beat);
      #1;
      check_eq("wready", 32'(bus.s_wready), 32'd1);
      check_eq("wlast_error", 32'(wlast_error),
               32'(bus.m_wvalid && (bus.m_wlast != last_cnt)));
      if (bus.m_wvalid) begin
        ref_mem[(idx + beat) % MemWords] = data[beat];
        beat++;
      end
      tick();
      n++;
    end
    bus.m_wvalid = 1'b0;
    bus.m_wlast  = 1'b0;
    if (beat <= int'(len)) check_eq("w_timeout", 32'd0, 32'd1);
  endtask

  task automatic recv_b();
    int stall = $urandom_range(0, 2);
    check_eq("bvalid", 32'(bus.s_bvalid), 32'd1);
    repeat (stall) begin
      tick();
      check_eq("bvalid_hold", 32'(bus.s_bvalid), 32'd1);
    end
    bus.m_bready = 1'b1;
    tick();
    bus.m_bready = 1'b0;
    check_eq("bvalid_drop", 32'(bus.s_bvalid), 32'd0);
  endtask

  // Checks rvalid/rdata every cycle so stalls and bubbles are both caught.
  task automatic recv_r(input int unsigned idx, input axi_burst_len_t len, input bit rand_ready,
                        input int abort_beat);
    int beat = 0;
    int n = 0;
    while (beat <= int'(len) && n < int'(TimeoutCycles) * 8) begin
      check_eq("rvalid", 32'(bus.s_rvalid), 32'd1);
      check_eq("rdata", bus.s_rdata, ref_mem[(idx + beat) % MemWords]);
      if (beat == abort_beat) return;
      bus.m_rready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
      if (bus.m_rready) beat++;
    end
    bus.m_rready = 1'b0;
    if (beat <= int'(len)) check_eq("r_timeout", 32'd0, 32'd1);
    check_eq("rvalid_end", 32'(bus.s_rvalid), 32'd0);
  endtask

  task automatic write_burst(input logic [31:0] addr, input axi_burst_len_t len,
                             input logic [31:0] data[$], input bit gaps);
    aw_handshake(addr, len);
    send_w(widx(addr), len, -1, gaps, data);
    recv_b();
  endtask

  task automatic read_burst(input logic [31:0] addr, input axi_burst_len_t len,
                            input bit rand_ready);
    ar_handshake(addr, len);
    recv_r(widx(addr), len, rand_ready, -1);
  endtask

  initial begin
    logic [31:0] d[$];
    logic [31:0] a;
    axi_burst_len_t l;

    idle_bus();
    #2;
    apply_reset();

    d = '{32'hDEAD_BEEF};
    write_burst(32'h40, 8'd0, d, 1'b0);
    read_burst(32'h40, 8'd0, 1'b0);

    d.delete();
    for (int i = 0; i < 8; i++) d.push_back(32'(i + 1));
    write_burst(32'h100, 8'd7, d, 1'b0);
    read_burst(32'h100, 8'd7, 1'b0);
    read_burst(32'h100, 8'd7, 1'b1);

    // Burst crossing the top of memory wraps to word 0.
    d.delete();
    for (int i = 0; i < 4; i++) d.push_back($urandom);
    write_burst((MemWords - 2) * 4, 8'd3, d, 1'b1);
    read_burst(32'h0, 8'd1, 1'b0);
    read_burst((MemWords - 2) * 4, 8'd3, 1'b1);

    for (int t = 0; t < 6; t++) begin
      a = $urandom & 32'hFFFF_FFFC;
      l = axi_burst_len_t'($urandom_range(0, 15));
      d.delete();
      for (int i = 0; i <= int'(l); i++) d.push_back($urandom);
      write_burst(a, l, d, 1'b1);
      read_burst(a ^ 32'h1000_0000, l, 1'b1);
    end

    // Arbitration after reset: read first, then write; early wlast on beat 2 of 4.
    apply_reset();
    bus.m_arvalid = 1'b1;
    bus.m_araddr  = 32'h100;
    bus.m_arlen   = 8'd0;
    bus.m_awvalid = 1'b1;
    bus.m_awaddr  = 32'h200;
    bus.m_awlen   = 8'd3;
    #1;
    check_eq("arb1_arready", 32'(bus.s_arready), 32'd1);
    check_eq("arb1_awready", 32'(bus.s_awready), 32'd0);
    tick();
    bus.m_arvalid = 1'b0;
    check_eq("busy_awready", 32'(bus.s_awready), 32'd0);
    recv_r(widx(32'h100), 8'd0, 1'b0, -1);
    bus.m_arvalid = 1'b1;
    #1;
    check_eq("arb2_awready", 32'(bus.s_awready), 32'd1);
    check_eq("arb2_arready", 32'(bus.s_arready), 32'd0);
    tick();
    bus.m_awvalid = 1'b0;
    bus.m_arvalid = 1'b0;
    d.delete();
    for (int i = 0; i < 4; i++) d.push_back($urandom);
    send_w(widx(32'h200), 8'd3, 1, 1'b0, d);
    recv_b();
    read_burst(32'h200, 8'd3, 1'b0);

    // Reset during beat 3 of a 16-beat read, then a clean re-read.
    d.delete();
    for (int i = 0; i < 16; i++) d.push_back($urandom);
    write_burst(32'h300, 8'd15, d, 1'b0);
    ar_handshake(32'h300, 8'd15);
    recv_r(widx(32'h300), 8'd15, 1'b0, 2);
    apply_reset();
    check_eq("post_rst_rvalid", 32'(bus.s_rvalid), 32'd0);
    read_burst(32'h300, 8'd15, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
